// File: rtl/ifd_pkg.sv
// Shared constants and event-state type for the five-bit filtered input capture block.
package ifd_pkg;

  localparam int NBIT       = 5;
  localparam int FILT_N_DEF = 8;
  localparam int FILT_W_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } evt_state_e;

endpackage

// File: rtl/ifd_filt_bit.sv
// One input bit: two-flop synchroniser, glitch filter counter, filtered level and edge pulses.
module ifd_filt_bit #(
  parameter int FILT_N = 8,
  parameter int FILT_W = 4
) (
  input  logic CK,
  input  logic CLR,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic upd,
  output logic q_next
);

  localparam logic [FILT_W-1:0] CNT_MAX = FILT_W'(FILT_N - 1);

  logic              r1_q, r1_d;
  logic              r2_q, r2_d;
  logic [FILT_W-1:0] cnt_q, cnt_d;
  logic              q_q, q_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  // NOTE: every signal gets a default before the if-chain so no latch is inferred.
  always_comb begin
    r1_d   = d;
    r2_d   = r1_q;
    cnt_d  = cnt_q;
    q_d    = q_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    upd    = 1'b0;
    if (r2_q == q_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      q_d    = r2_q;
      cnt_d  = '0;
      rise_d = r2_q;
      fall_d = ~r2_q;
      upd    = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    q_next = q_d;
  end

  // NOTE: state flops use non-blocking assignments so all bits update from pre-edge values.
  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      r1_q   <= 1'b0;
      r2_q   <= 1'b0;
      cnt_q  <= '0;
      q_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      r1_q   <= r1_d;
      r2_q   <= r2_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/ifd5_filt.sv
// Five-bit filtered input capture with change-event latch (CHG/SNAP/OVR) and ACK handshake.
module ifd5_filt
  import ifd_pkg::*;
#(
  parameter int FILT_N = FILT_N_DEF,
  parameter int FILT_W = FILT_W_DEF
) (
  input  logic            CK,
  input  logic            CLR,
  input  logic            D0,
  input  logic            D1,
  input  logic            D2,
  input  logic            D3,
  input  logic            D4,
  input  logic            ACK,
  output logic            Q0,
  output logic            Q1,
  output logic            Q2,
  output logic            Q3,
  output logic            Q4,
  output logic [NBIT-1:0] RISE,
  output logic [NBIT-1:0] FALL,
  output logic            CHG,
  output logic [NBIT-1:0] SNAP,
  output logic            OVR
);

  logic [NBIT-1:0] d_vec, q_vec, upd_vec, qn_vec;
  logic            any_upd;

  evt_state_e      state_q, state_d;
  logic [NBIT-1:0] snap_q, snap_d;
  logic            ovr_q, ovr_d;

  assign d_vec = {D4, D3, D2, D1, D0};

  for (genvar i = 0; i < NBIT; i++) begin : g_bit
    ifd_filt_bit #(
      .FILT_N (FILT_N),
      .FILT_W (FILT_W)
    ) u_bit (
      .CK     (CK),
      .CLR    (CLR),
      .d      (d_vec[i]),
      .q      (q_vec[i]),
      .rise   (RISE[i]),
      .fall   (FALL[i]),
      .upd    (upd_vec[i]),
      .q_next (qn_vec[i])
    );
  end

  // Bits updating on the same edge collapse into one event.
  assign any_upd = |upd_vec;

  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      snap_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_upd) state_d = PEND;
      PEND:    if (ACK && !any_upd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SNAP reloads only when the event is (re)opened; OVR flags updates the consumer missed.
  always_comb begin
    snap_d = snap_q;
    ovr_d  = ovr_q;
    case (state_q)
      IDLE: begin
        ovr_d = 1'b0;
        if (any_upd) snap_d = qn_vec;
      end
      PEND: begin
        if (ACK) begin
          ovr_d = 1'b0;
          if (any_upd) snap_d = qn_vec;
        end else if (any_upd) begin
          ovr_d = 1'b1;
        end
      end
      default: ovr_d = 1'b0;
    endcase
  end

  assign CHG  = (state_q == PEND);
  assign SNAP = snap_q;
  assign OVR  = ovr_q;
  assign {Q4, Q3, Q2, Q1, Q0} = q_vec;

endmodule

// File: tb/tb_ifd5_filt.sv
// Directed bench for ifd5_filt: FILT_N=8 instance for filter/event checks, FILT_N=1 for latency.
module tb_ifd5_filt;

  logic       ck, clr, ack;
  logic [4:0] d;

  logic       a_q0, a_q1, a_q2, a_q3, a_q4, a_chg, a_ovr;
  logic [4:0] a_rise, a_fall, a_snap;
  logic       b_q0, b_q1, b_q2, b_q3, b_q4, b_chg, b_ovr;
  logic [4:0] b_rise, b_fall, b_snap;
  logic [4:0] a_q, b_q;

  int n_vec = 0;
  int n_err = 0;

  assign a_q = {a_q4, a_q3, a_q2, a_q1, a_q0};
  assign b_q = {b_q4, b_q3, b_q2, b_q1, b_q0};

  ifd5_filt #(.FILT_N(8), .FILT_W(4)) dut8 (
    .CK(ck), .CLR(clr), .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]), .D4(d[4]), .ACK(ack),
    .Q0(a_q0), .Q1(a_q1), .Q2(a_q2), .Q3(a_q3), .Q4(a_q4),
    .RISE(a_rise), .FALL(a_fall), .CHG(a_chg), .SNAP(a_snap), .OVR(a_ovr)
  );

  ifd5_filt #(.FILT_N(1), .FILT_W(4)) dut1 (
    .CK(ck), .CLR(clr), .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]), .D4(d[4]), .ACK(ack),
    .Q0(b_q0), .Q1(b_q1), .Q2(b_q2), .Q3(b_q3), .Q4(b_q4),
    .RISE(b_rise), .FALL(b_fall), .CHG(b_chg), .SNAP(b_snap), .OVR(b_ovr)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic do_reset();
    d   = '0;
    ack = 1'b0;
    clr = 1'b1;
    #2;
    clr = 1'b0;
    repeat (3) tick();
  endtask

  // Counts edges (capture edge = 1) until the signal selected rises; gives up at 30.
  task automatic wait_chg(output int n);
    n = 0;
    while (!a_chg && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_q(input int bit_i, output int n);
    n = 0;
    while (!a_q[bit_i] && n < 30) begin
      tick();
      n++;
    end
  endtask

  logic cap [0:63];
  int   n;
  int   rise_cnt, fall_cnt;
  logic seen_q, seen_chg, seen_rise;

  initial begin
    d   = '0;
    ack = 1'b0;
    clr = 1'b1;
    repeat (2) tick();

    // Reset mid-count, then release with all pins high.
    clr = 1'b0;
    d   = 5'b11111;
    repeat (5) tick();
    clr = 1'b1;
    #1;
    check("rst_q",    a_q,    5'b00000);
    check("rst_rise", a_rise, 5'b00000);
    check("rst_chg",  a_chg,  1'b0);
    check("rst_snap", a_snap, 5'b00000);
    check("rst_ovr",  a_ovr,  1'b0);
    tick();
    tick();
    clr = 1'b0;
    repeat (9) tick();
    check("rel_q_early", a_q, 5'b00000);
    tick();
    check("rel_q",    a_q,    5'b11111);
    check("rel_rise", a_rise, 5'b11111);
    check("rel_chg",  a_chg,  1'b1);
    check("rel_snap", a_snap, 5'b11111);
    check("rel_ovr",  a_ovr,  1'b0);
    tick();
    check("rel_rise_end", a_rise, 5'b00000);
    check("rel_chg_hold", a_chg,  1'b1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("rel_ack_chg", a_chg, 1'b0);

    // Glitch of 7 cycles on D2 must be rejected.
    do_reset();
    seen_q = 1'b0; seen_chg = 1'b0; seen_rise = 1'b0;
    d = 5'b00100;
    repeat (7) begin
      tick();
      seen_q |= a_q2; seen_chg |= a_chg; seen_rise |= a_rise[2];
    end
    d = 5'b00000;
    repeat (15) begin
      tick();
      seen_q |= a_q2; seen_chg |= a_chg; seen_rise |= a_rise[2];
    end
    check("g7_q2",   seen_q,    1'b0);
    check("g7_chg",  seen_chg,  1'b0);
    check("g7_rise", seen_rise, 1'b0);

    // Pulse of 8 cycles on D2 is accepted exactly once.
    seen_q = 1'b0; seen_chg = 1'b0; rise_cnt = 0;
    d = 5'b00100;
    repeat (8) begin
      tick();
      seen_q |= a_q2; seen_chg |= a_chg; rise_cnt += int'(a_rise[2]);
    end
    d = 5'b00000;
    repeat (6) begin
      tick();
      seen_q |= a_q2; seen_chg |= a_chg; rise_cnt += int'(a_rise[2]);
    end
    check("g8_q2",   seen_q,   1'b1);
    check("g8_chg",  seen_chg, 1'b1);
    check("g8_rise", rise_cnt, 1);

    // Handshake and overrun.
    do_reset();
    d = 5'b00001;
    wait_chg(n);
    check("hs_lat",  n,      10);
    check("hs_snap", a_snap, 5'b00001);
    check("hs_ovr",  a_ovr,  1'b0);
    d = 5'b00011;
    wait_q(1, n);
    check("hs_q1_lat",  n,      10);
    check("hs_ov_chg",  a_chg,  1'b1);
    check("hs_ov_snap", a_snap, 5'b00001);
    check("hs_ov_ovr",  a_ovr,  1'b1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("hs_ack_chg", a_chg, 1'b0);
    check("hs_ack_ovr", a_ovr, 1'b0);
    tick();
    check("hs_ack_ignored", a_chg, 1'b0);

    // ACK coinciding with an update keeps the event open with a fresh snapshot.
    d = 5'b00111;
    wait_chg(n);
    check("sim_pend_snap", a_snap, 5'b00111);
    d = 5'b01111;
    repeat (9) tick();
    check("sim_pre_q3",   a_q3,   1'b0);
    check("sim_pre_snap", a_snap, 5'b00111);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("sim_q3",   a_q3,   1'b1);
    check("sim_chg",  a_chg,  1'b1);
    check("sim_snap", a_snap, 5'b01111);
    check("sim_ovr",  a_ovr,  1'b0);

    // Multiple bits on one edge form a single event.
    do_reset();
    d = 5'b10101;
    wait_chg(n);
    check("mb_lat",  n,      10);
    check("mb_q",    a_q,    5'b10101);
    check("mb_rise", a_rise, 5'b10101);
    check("mb_snap", a_snap, 5'b10101);
    check("mb_ovr",  a_ovr,  1'b0);
    tick();
    check("mb_rise_end", a_rise, 5'b00000);
    check("mb_ovr_end",  a_ovr,  1'b0);

    // FILT_N=1 instance: Q4 is the pin value captured two edges earlier.
    do_reset();
    for (int i = 0; i < 64; i++) cap[i] = 1'b0;
    rise_cnt = 0;
    fall_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      d[4] = (k >= 4) ? (((k - 4) / 3) % 2 == 0) : 1'b0;
      cap[k] = d[4];
      tick();
      if (k >= 4) begin
        check($sformatf("f1_q4_%0d", k), b_q4, cap[k-2]);
        check($sformatf("f1_rf_%0d", k), {b_rise[4], b_fall[4]},
              {cap[k-2] & ~cap[k-3], ~cap[k-2] & cap[k-3]});
        rise_cnt += int'(b_rise[4]);
        fall_cnt += int'(b_fall[4]);
      end
    end
    check("f1_rise_total", rise_cnt, 5);
    check("f1_fall_total", fall_cnt, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
